// File: rtl/motion_pkg.sv
// motion_pkg: direction encodings, screen bounds and helpers shared by the player motion logic.
package motion_pkg;
    localparam logic [3:0] DIR_IDLE = 4'b0000;
    localparam logic [3:0] DIR_R    = 4'b0001;
    localparam logic [3:0] DIR_D    = 4'b0010;
    localparam logic [3:0] DIR_U    = 4'b0100;
    localparam logic [3:0] DIR_L    = 4'b1000;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int PLAYER_SIZE_X = 37;
    localparam int PLAYER_SIZE_Y = 42;
    localparam int DEF_X_MAX     = SCREEN_W - PLAYER_SIZE_X;
    localparam int DEF_Y_MAX     = SCREEN_H - PLAYER_SIZE_Y;
    // R<->L and D<->U sit at mirrored bit positions, so reversing the bits gives the opposite
    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction
endpackage

// File: rtl/turn_fifo.sv
// turn_fifo: small circular buffer of pending one-hot turns with head/tail peek and same-cycle push+pop.
module turn_fifo import motion_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [3:0]    din,
    output logic [3:0]    head,
    output logic [3:0]    tail,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    logic [3:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;
    always_comb begin
        full    = level == LW'(DEPTH);
        empty   = level == '0;
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem[rd];
        tail    = mem[wr == '0 ? LAST : wr - 1'b1];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd    <= '0;
            wr    <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_IDLE;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr      <= wr == LAST ? '0 : wr + 1'b1;
            end
            if (do_pop) rd <= rd == LAST ? '0 : rd + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: queues filtered key presses as turns and steps the player position on each game tick.
module player_motion_ctrl import motion_pkg::*; #(
    parameter int COORD_W     = 16,
    parameter int STEP        = 5,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int QUEUE_DEPTH = 2,
    parameter int WRAP_MODE   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         key_edge,
    input  logic                               game_tick,
    input  logic                               pause,
    output logic [COORD_W-1:0]                 pos_x,
    output logic [COORD_W-1:0]                 pos_y,
    output logic [3:0]                         direction,
    output logic                               facing,
    output logic                               moved,
    output logic                               wall_hit,
    output logic                               turn_drop,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_level
);
    localparam int LW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [COORD_W:0]   STEP_W = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W-1:0] XLO = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] XHI = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YLO = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] YHI = COORD_W'(Y_MAX);
    logic tick, pop, push, drop, full, empty, valid;
    logic [3:0] head, tail, sel, new_dir, ref_dir;
    logic [COORD_W:0] ax, ay;
    // Returns {bound_hit, next_coordinate}; the extra bit of s exposes underflow below zero
    function automatic logic [COORD_W:0] axis(input logic [COORD_W-1:0] p, input logic up, input logic dn,
                                              input logic [COORD_W-1:0] lo, input logic [COORD_W-1:0] hi);
        logic [COORD_W:0] s;
        logic over, under;
        s     = up ? {1'b0, p} + STEP_W : {1'b0, p} - STEP_W;
        over  = up && s > {1'b0, hi};
        under = dn && (s[COORD_W] || s[COORD_W-1:0] < lo);
        return over ? {1'b1, WRAP_MODE != 0 ? lo : hi} :
               under ? {1'b1, WRAP_MODE != 0 ? hi : lo} :
               {1'b0, (up | dn) ? s[COORD_W-1:0] : p};
    endfunction
    always_comb begin
        tick    = game_tick & ~pause;
        pop     = tick & ~empty;
        new_dir = pop ? head : direction;
        ref_dir = (pop ? queue_level > LW'(1) : !empty) ? tail : new_dir;
        sel     = key_edge[3] ? DIR_R : key_edge[2] ? DIR_D : key_edge[0] ? DIR_L :
                  key_edge[1] ? DIR_U : DIR_IDLE;
        valid   = sel != DIR_IDLE && sel != ref_dir && sel != opposite(ref_dir);
        push    = valid & (~full | pop);
        drop    = valid & full & ~pop;
        ax      = axis(pos_x, new_dir == DIR_R, new_dir == DIR_L, XLO, XHI);
        ay      = axis(pos_y, new_dir == DIR_D, new_dir == DIR_U, YLO, YHI);
    end
    turn_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (sel),
        .head  (head),
        .tail  (tail),
        .full  (full),
        .empty (empty),
        .level (queue_level)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x     <= COORD_W'(START_X);
            pos_y     <= COORD_W'(START_Y);
            direction <= DIR_IDLE;
            facing    <= 1'b0;
            moved     <= 1'b0;
            wall_hit  <= 1'b0;
            turn_drop <= 1'b0;
        end else begin
            turn_drop <= drop & ~pause;
            moved     <= tick && (ax[COORD_W-1:0] != pos_x || ay[COORD_W-1:0] != pos_y);
            wall_hit  <= tick & (ax[COORD_W] | ay[COORD_W]);
            if (tick) begin
                direction <= new_dir;
                pos_x     <= ax[COORD_W-1:0];
                pos_y     <= ay[COORD_W-1:0];
                facing    <= new_dir == DIR_L ? 1'b1 : new_dir == DIR_R ? 1'b0 : facing;
            end
        end
    end
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed checks of turn queueing, clamp and wrap movement, pause and async reset.
module tb_player_motion_ctrl;
    localparam logic [3:0] KR = 4'b1000, KD = 4'b0100, KU = 4'b0010, KL = 4'b0001;
    logic clk = 1'b0, rst = 1'b0, pause = 1'b0;
    logic [3:0] key_a = '0, key_b = '0;
    logic tick_a = 1'b0, tick_b = 1'b0;
    logic [15:0] ax, ay, bx, by;
    logic [3:0] a_dir, b_dir;
    logic a_face, a_moved, a_hit, a_drop, b_face, b_moved, b_hit, b_drop;
    logic [1:0] a_lvl, b_lvl;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    player_motion_ctrl u_clamp (
        .clk(clk), .rst(rst), .key_edge(key_a), .game_tick(tick_a), .pause(pause),
        .pos_x(ax), .pos_y(ay), .direction(a_dir), .facing(a_face), .moved(a_moved),
        .wall_hit(a_hit), .turn_drop(a_drop), .queue_level(a_lvl)
    );
    player_motion_ctrl #(.WRAP_MODE(1), .START_X(598), .START_Y(7)) u_wrap (
        .clk(clk), .rst(rst), .key_edge(key_b), .game_tick(tick_b), .pause(pause),
        .pos_x(bx), .pos_y(by), .direction(b_dir), .facing(b_face), .moved(b_moved),
        .wall_hit(b_hit), .turn_drop(b_drop), .queue_level(b_lvl)
    );
    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic step(input logic [3:0] ka, input logic ta, input logic [3:0] kb = 4'b0, input logic tb = 1'b0);
        @(negedge clk);
        key_a = ka; tick_a = ta; key_b = kb; tick_b = tb;
        @(posedge clk);
        #1;
        key_a = '0; tick_a = 1'b0; key_b = '0; tick_b = 1'b0;
    endtask
    initial begin
        #12;
        check("rst_x", ax, 0); check("rst_y", ay, 0); check("rst_dir", a_dir, 0);
        check("rst_lvl", a_lvl, 0); check("rst_face", a_face, 0); check("rst_moved", a_moved, 0);
        @(negedge clk) rst = 1'b1;
        step(KR, 0);           check("push_r_lvl", a_lvl, 1);
        step(0, 1);
        check("mv1_dir", a_dir, 1); check("mv1_x", ax, 5); check("mv1_y", ay, 0);
        check("mv1_face", a_face, 0); check("mv1_moved", a_moved, 1);
        step(KL, 0);           check("rev_lvl", a_lvl, 0); check("rev_drop", a_drop, 0);
        step(KD, 0);           check("q_d_lvl", a_lvl, 1);
        step(KL, 0);           check("q_l_lvl", a_lvl, 2);
        step(KU, 0);           check("full_drop", a_drop, 1); check("full_lvl", a_lvl, 2);
        step(0, 0);            check("drop_pulse_end", a_drop, 0);
        step(0, 1);            check("pop_d_dir", a_dir, 2); check("pop_d_y", ay, 5); check("pop_d_lvl", a_lvl, 1);
        step(KU, 0);           check("q_u_lvl", a_lvl, 2);
        step(KR, 1);
        check("pp_dir", a_dir, 8); check("pp_face", a_face, 1); check("pp_x", ax, 0);
        check("pp_lvl", a_lvl, 2); check("pp_drop", a_drop, 0); check("pp_hit", a_hit, 0);
        step(0, 1);            check("up_dir", a_dir, 4); check("up_y", ay, 0); check("up_face", a_face, 1);
        step(0, 1);            check("r_face", a_face, 0); check("r_x", ax, 5); check("r_lvl", a_lvl, 0);
        for (int i = 0; i < 119; i++) step(0, 1);
        check("run_x", ax, 600);
        step(0, 1);            check("clamp_x", ax, 603); check("clamp_hit", a_hit, 1); check("clamp_moved", a_moved, 1);
        step(0, 1);            check("wall_x", ax, 603); check("wall_hit", a_hit, 1); check("wall_moved", a_moved, 0);
        pause = 1'b1;
        step(KD, 1); step(0, 1); step(0, 1);
        check("pause_x", ax, 603); check("pause_y", ay, 0); check("pause_lvl", a_lvl, 1);
        check("pause_dir", a_dir, 1); check("pause_hit", a_hit, 0); check("pause_moved", a_moved, 0);
        pause = 1'b0;
        step(0, 1);            check("resume_dir", a_dir, 2); check("resume_y", ay, 5); check("resume_moved", a_moved, 1);
        step(0, 0, KR, 0);     check("w_lvl", b_lvl, 1);
        step(0, 0, 0, 1);      check("w_x603", bx, 603); check("w_nohit", b_hit, 0);
        step(0, 0, 0, 1);      check("w_x0", bx, 0); check("w_xhit", b_hit, 1); check("w_xmoved", b_moved, 1);
        step(0, 0, KU, 0);
        step(0, 0, 0, 1);      check("w_y2", by, 2); check("w_ydir", b_dir, 4);
        step(0, 0, 0, 1);      check("w_y438", by, 438); check("w_yhit", b_hit, 1);
        step(KU, 0);           check("pre_rst_lvl", a_lvl, 0);
        step(KR, 0);           check("pre_rst_lvl2", a_lvl, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_x", ax, 0); check("arst_y", ay, 0); check("arst_dir", a_dir, 0);
        check("arst_lvl", a_lvl, 0); check("arst_bx", bx, 598); check("arst_by", by, 7);
        @(negedge clk) rst = 1'b1;
        step(KD, 0);           check("post_rst_lvl", a_lvl, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
